ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single 32-bit RAM port among N_REQ requesters, e.g. instruction fetch plus the push/pop/load/store ISA units.
- Each requester port carries the same txs/txe handshake that the RAM port uses, so existing units connect unchanged.
- Grants one transaction at a time, round-robin, and registers read data per grant.
- Sits between the ISA execution units and the RAM model.

Parameters:
- N_REQ, 2, number of requester ports (legal 2..8).
- ADDR_W, 64, address width.
- DATA_W, 32, RAM word width.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_txs  input  N_REQ  per-port request strobe: 1 = transaction requested, 0 = release.
- req_re  input  N_REQ  per-port read enable.
- req_we  input  N_REQ  per-port write enable.
- req_addr  input  N_REQ*ADDR_W  packed addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- req_wd  input  N_REQ*DATA_W  packed write data, same packing.
- req_txe  output  N_REQ  per-port completion flag.
- req_rdata  output  DATA_W  read data of the last completed read; shared by all ports.
- ram_txs  output  1  RAM transaction strobe.
- ram_re  output  1  RAM read enable.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_wd  output  DATA_W  RAM write data.
- ram_txe  input  1  RAM completion flag.
- ram_out  input  DATA_W  RAM read data.
- grant_id  output  3  index of the current or last granted port.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (async, rst_n=0):
  - ram_txs, ram_re, ram_we = 0; ram_addr, ram_wd = 0.
  - req_txe = 0; req_rdata = 0; grant_id = 0; busy = 0.
  - last_grant = N_REQ-1, so port 0 wins first.
  - state = IDLE.
- Port handshake:
  - Requester holds re/we/addr/wd stable while txs=1.
  - Arbiter sets req_txe[g]=1 on completion and holds it until req_txs[g]=0.
  - Arbiter then clears req_txe[g] on the next edge.
  - A port is pending when req_txs[i]=1 and req_txe[i]=0.
- IDLE:
  - Outputs: ram_txs=0.
  - Transition: if ram_txe=0 and any port is pending, select the first pending port scanning last_grant+1 upward, mod N_REQ.
  - Latch grant_id, addr, wd, re, we; go ISSUE.
  - If ram_txe=1, stay in IDLE; the RAM has not yet returned to zero.
- ISSUE:
  - Drive ram_txs=1, ram_addr, ram_wd from the latch.
  - ram_we = latched we; ram_re = latched re & ~we.
  - Go WAIT.
- WAIT (on ram_txe=1):
  - If read, req_rdata <= ram_out.
  - ram_txs, ram_re, ram_we <= 0; req_txe[g] <= 1; go DONE.
- DONE (on req_txs[g]=0):
  - req_txe[g] <= 0; last_grant <= g; go IDLE.
- Latency:
  - Minimum 2 cycles from the pending edge to ram_txs=1: the IDLE sample plus ISSUE.
  - req_txe rises on the edge after ram_txe is sampled high.
- Both re and we set: treated as a write; req_rdata unchanged.
- Both re and we clear: null transaction.
  - IDLE goes directly to DONE with req_txe[g]=1.
  - RAM is never strobed.
- Requester drops txs during ISSUE/WAIT:
  - The RAM transaction is not aborted; it completes normally.
  - req_txe[g] is high for exactly one cycle in DONE, then clears.
- Request inputs of ungranted ports are ignored; only the latched copy drives the RAM.
- Simultaneous pending ports: exactly one is granted per IDLE pass; the others keep txs=1 and wait.
- Reset mid-transaction: all outputs return to reset values immediately; state returns to IDLE; no req_txe is produced.
- grant_id holds its value after DONE until the next grant.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: IDLE always selects the lowest-index pending port; last_grant is unused.
- Undefined: round-robin as described under Behaviour.

Test Plan:
- Port 1 read, addr=0x10; RAM returns 0xDEADBEEF:
  - ram_addr=0x10, ram_re=1, ram_we=0.
  - req_rdata=0xDEADBEEF.
  - req_txe[1] rises, then falls one cycle after req_txs[1] drops.
- Ports 0 and 1 each request continuously (re-request immediately after release), N_REQ=2, from reset:
  - Grant order 0,1,0,1.
  - With RAM_ARB_FIXED_PRIO_EN defined: 0,0,0 and port 1 is starved.
- Port 0 write, addr=0x20, wd=0x12345678, re=1 also set:
  - ram_we=1, ram_re=0, ram_wd=0x12345678.
  - req_rdata keeps its prior value.
- ram_txe held high for 5 cycles while port 0 is pending:
  - ram_txs stays 0 and busy=0 until ram_txe=0.
  - Then ram_txs=1 within 2 cycles.
- Port 0 drops req_txs in WAIT:
  - RAM completes; req_txe[0] is high for exactly 1 cycle.
  - Next grant proceeds normally.
- rst_n pulsed low during WAIT:
  - ram_txs=0, req_txe=0, busy=0 immediately (asynchronous).
  - After release, a new port 1 request completes normally.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin arbiter sharing one txs/txe RAM port among N_REQ requesters.
// Define RAM_ARB_FIXED_PRIO_EN to select the lowest-index pending port instead of round-robin.
module ram_port_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_txs,
  input  logic [N_REQ-1:0]          req_re,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wd,
  output logic [N_REQ-1:0]          req_txe,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      ram_txs,
  output logic                      ram_re,
  output logic                      ram_we,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_wd,
  input  logic                      ram_txe,
  input  logic [DATA_W-1:0]         ram_out,
  output logic [2:0]                grant_id,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [N_REQ-1:0]  pending;
  logic [N_REQ-1:0]  gnt_oh;
  logic              sel_found;
  logic [2:0]        sel;
  logic              sel_re, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wd;
  logic              start;

  logic              lat_re, lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wd;

`ifndef RAM_ARB_FIXED_PRIO_EN
  logic [2:0]        last_grant;
`endif

  assign pending = req_txs & ~req_txe;
  assign gnt_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign busy    = (state != IDLE);
  assign start   = (state == IDLE) && !ram_txe && sel_found;

  always_comb begin
    sel_found = 1'b0;
    sel       = 3'd0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_found = 1'b1;
        sel       = 3'(i);
      end
    end
`else
    // Scan last_grant+1 upward, wrapping, so the most recent winner is tried last.
    for (int k = 1; k <= N_REQ; k++) begin
      int idx;
      idx = int'(last_grant) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      for (int i = 0; i < N_REQ; i++) begin
        if (!sel_found && pending[i] && (i == idx)) begin
          sel_found = 1'b1;
          sel       = 3'(i);
        end
      end
    end
`endif
  end

  always_comb begin
    sel_re   = 1'b0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_wd   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == 3'(i)) begin
        sel_re   = req_re[i];
        sel_we   = req_we[i];
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_wd   = req_wd[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        // A null request (neither re nor we) completes without touching the RAM.
        if (start) next_state = (sel_re || sel_we) ? ISSUE : DONE;
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (ram_txe) next_state = DONE;
      end
      DONE: begin
        if ((req_txs & gnt_oh) == '0) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_txs    <= 1'b0;
      ram_re     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wd     <= '0;
      req_txe    <= '0;
      req_rdata  <= '0;
      grant_id   <= 3'd0;
      lat_re     <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wd     <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_grant <= 3'(N_REQ - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            grant_id <= sel;
            lat_re   <= sel_re;
            lat_we   <= sel_we;
            lat_addr <= sel_addr;
            lat_wd   <= sel_wd;
            if (!sel_re && !sel_we)
              req_txe <= req_txe | ({{(N_REQ-1){1'b0}}, 1'b1} << sel);
          end
        end
        ISSUE: begin
          ram_txs  <= 1'b1;
          ram_addr <= lat_addr;
          ram_wd   <= lat_wd;
          ram_we   <= lat_we;
          ram_re   <= lat_re & ~lat_we;
        end
        WAIT: begin
          if (ram_txe) begin
            if (lat_re && !lat_we) req_rdata <= ram_out;
            ram_txs <= 1'b0;
            ram_re  <= 1'b0;
            ram_we  <= 1'b0;
            req_txe <= req_txe | gnt_oh;
          end
        end
        DONE: begin
          if ((req_txs & gnt_oh) == '0) begin
            req_txe    <= req_txe & ~gnt_oh;
`ifndef RAM_ARB_FIXED_PRIO_EN
            last_grant <= grant_id;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed table-driven bench for ram_port_arbiter.
module tb_ram_port_arbiter;
  localparam int N_REQ  = 2;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_txs, req_re, req_we, req_txe;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wd;
  logic [DATA_W-1:0]       req_rdata;
  logic                    ram_txs, ram_re, ram_we, ram_txe;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       ram_wd, ram_out;
  logic [2:0]              grant_id;
  logic                    busy;

  ram_port_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_txs(req_txs), .req_re(req_re), .req_we(req_we),
    .req_addr(req_addr), .req_wd(req_wd),
    .req_txe(req_txe), .req_rdata(req_rdata),
    .ram_txs(ram_txs), .ram_re(ram_re), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wd(ram_wd),
    .ram_txe(ram_txe), .ram_out(ram_out),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        re;
    logic        we;
    logic [63:0] addr;
    logic [31:0] wd;
    logic [31:0] ram_data;
    logic        exp_re;
    logic        exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_txs  = '0; req_re = '0; req_we = '0;
    req_addr = '0; req_wd = '0;
    ram_txe  = 1'b0; ram_out = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_port(input int p, input logic re, input logic we,
                          input logic [63:0] addr, input logic [31:0] wd);
    req_re[p] = re;
    req_we[p] = we;
    req_addr[p*ADDR_W +: ADDR_W] = addr;
    req_wd[p*DATA_W +: DATA_W]   = wd;
    req_txs[p] = 1'b1;
  endtask

  // Waits up to 20 cycles for the RAM strobe (or req_txe for null requests); returns cycles waited.
  task automatic wait_strobe(input int p, output int cnt);
    cnt = 0;
    while (!ram_txs && !req_txe[p] && cnt < 20) begin
      tick();
      cnt++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cnt;
    set_port(v.port, v.re, v.we, v.addr, v.wd);
    wait_strobe(v.port, cnt);
    if (!v.re && !v.we) begin
      check("null_latency", 64'(cnt), 64'd1);
      check("null_no_strobe", {63'd0, ram_txs}, 64'd0);
      check("null_txe", {63'd0, req_txe[v.port]}, 64'd1);
    end else begin
      check("latency", 64'(cnt), 64'd2);
      check("ram_addr", ram_addr, v.addr);
      check("ram_re", {63'd0, ram_re}, {63'd0, v.exp_re});
      check("ram_we", {63'd0, ram_we}, {63'd0, v.exp_we});
      if (v.exp_we) check("ram_wd", {32'd0, ram_wd}, {32'd0, v.wd});
      ram_out = v.ram_data;
      ram_txe = 1'b1;
      tick();
      check("txe_rise", {63'd0, req_txe[v.port]}, 64'd1);
      check("ram_txs_drop", {63'd0, ram_txs}, 64'd0);
      ram_txe = 1'b0;
    end
    check("grant_id", {61'd0, grant_id}, 64'(v.port));
    check("rdata", {32'd0, req_rdata}, {32'd0, v.exp_rdata});
    req_txs[v.port] = 1'b0;
    tick();
    check("txe_fall", {63'd0, req_txe[v.port]}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int cnt;
    int order[4];
    int exp_order[4];

    vecs[0] = '{1, 1'b1, 1'b0, 64'h10, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{0, 1'b1, 1'b1, 64'h20, 32'h12345678, 32'hAAAAAAAA, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{1, 1'b0, 1'b1, 64'h30, 32'hCAFEF00D, 32'hBBBBBBBB, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[3] = '{0, 1'b1, 1'b0, 64'h40, 32'h0,        32'h01234567, 1'b1, 1'b0, 32'h01234567};
    vecs[4] = '{1, 1'b0, 1'b0, 64'h50, 32'h0,        32'h0,        1'b0, 1'b0, 32'h01234567};

    do_reset();
    check("rst_ram_txs", {63'd0, ram_txs}, 64'd0);
    check("rst_req_txe", {62'd0, req_txe}, 64'd0);
    check("rst_rdata", {32'd0, req_rdata}, 64'd0);
    check("rst_grant", {61'd0, grant_id}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ram_addr", ram_addr, 64'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Both ports re-request immediately after each release.
    do_reset();
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    set_port(0, 1'b1, 1'b0, 64'h100, 32'h0);
    set_port(1, 1'b1, 1'b0, 64'h200, 32'h0);
    for (int n = 0; n < 4; n++) begin
      wait_strobe(0, cnt);
      check("rr_strobe", {63'd0, ram_txs}, 64'd1);
      order[n] = int'(grant_id);
      ram_out = 32'(n);
      ram_txe = 1'b1;
      tick();
      ram_txe = 1'b0;
      req_txs[order[n]] = 1'b0;
      tick();
      req_txs[order[n]] = 1'b1;
      check("rr_order", 64'(order[n]), 64'(exp_order[n]));
    end
    req_txs = '0;
    tick(); tick();

    // RAM completion still high: arbiter must not start.
    do_reset();
    ram_txe = 1'b1;
    set_port(0, 1'b1, 1'b0, 64'h60, 32'h0);
    for (int n = 0; n < 5; n++) begin
      tick();
      check("txe_hold_idle", {62'd0, ram_txs, busy}, 64'd0);
    end
    ram_txe = 1'b0;
    wait_strobe(0, cnt);
    check("txe_hold_latency", 64'(cnt), 64'd2);
    ram_out = 32'h0BADF00D;
    ram_txe = 1'b1;
    tick();
    ram_txe = 1'b0;
    check("txe_hold_rdata", {32'd0, req_rdata}, 64'h0BADF00D);
    req_txs[0] = 1'b0;
    tick();

    // Requester drops txs while in WAIT.
    set_port(0, 1'b1, 1'b0, 64'h70, 32'h0);
    wait_strobe(0, cnt);
    check("drop_strobe", {63'd0, ram_txs}, 64'd1);
    req_txs[0] = 1'b0;
    tick();
    ram_out = 32'h00000055;
    ram_txe = 1'b1;
    tick();
    ram_txe = 1'b0;
    check("drop_txe_hi", {63'd0, req_txe[0]}, 64'd1);
    tick();
    check("drop_txe_lo", {63'd0, req_txe[0]}, 64'd0);
    check("drop_rdata", {32'd0, req_rdata}, 64'h55);
    run_vec('{1, 1'b1, 1'b0, 64'h80, 32'h0, 32'h77777777, 1'b1, 1'b0, 32'h77777777});

    // Asynchronous reset during WAIT.
    set_port(0, 1'b1, 1'b0, 64'h90, 32'h0);
    wait_strobe(0, cnt);
    check("mid_rst_strobe", {63'd0, ram_txs}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_txs", {63'd0, ram_txs}, 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_txe", {62'd0, req_txe}, 64'd0);
    req_txs = '0;
    tick();
    rst_n = 1'b1;
    tick();
    run_vec('{1, 1'b1, 1'b0, 64'hA0, 32'h0, 32'hFEEDFACE, 1'b1, 1'b0, 32'hFEEDFACE});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
